// File: rtl/whack_pkg.sv
// Shared FSM states, hole constants and whack decode helper for the whack-a-mole game controller.
// Pure definitions: no latency and no flow control of its own.
package whack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_PLAY = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   localparam logic [2:0] NO_MOLE   = 3'd5;
   localparam int         NUM_HOLES = 5;

   // One-hot button pattern that scores a hit for a given mole hole; all-zero when no mole is up.
   function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [2:0] pos);
      hole_mask = (pos < NO_MOLE) ? (NUM_HOLES'(1) << pos) : '0;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running seconds divider: o_tick pulses on the last cycle of every CLK_DIV enabled cycles.
// Zero latency from the count register; i_clr restarts the count so no partial second survives.
module tick_gen #(
   parameter int CLK_DIV = 100000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [27:0] LAST = 28'(CLK_DIV - 1);

   logic [27:0] count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_clr) begin
         count <= '0;
      end else if (i_en) begin
         count <= (count == LAST) ? '0 : count + 28'd1;
      end
   end

   assign o_tick = i_en && (count == LAST);

endmodule

// File: rtl/whack_game_controller.sv
// Whack-a-mole game sequencer: runs IDLE/ARM/PLAY/OVER, scores whacks, counts misses, times the round.
// All outputs registered, one cycle after the causing input; inputs are pulses with no backpressure.
module whack_game_controller
   import whack_pkg::*;
#(
   parameter int CLK_DIV      = 100000000,
   parameter int GAME_SECONDS = 60,
   parameter int MAX_MISSES   = 3,
   parameter int SCORE_W      = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [4:0]         i_whack,
   input  logic [2:0]         i_mole_position,
   input  logic               i_position_changed,
   output logic               o_restart_game,
   output logic               o_change_position,
   output logic               o_game_over,
   output logic [SCORE_W-1:0] o_score,
   output logic [2:0]         o_misses,
   output logic [6:0]         o_time_left,
   output logic [1:0]         o_state
);

   localparam logic [6:0]         TIME_INIT = 7'(GAME_SECONDS);
   localparam logic [2:0]         MISS_MAX  = 3'(MAX_MISSES);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t     state;
   logic       hit_flag;
   logic       pending;
   logic [2:0] prev_pos;
   logic       tick;

   logic       hit_live;
   logic       whack_seen;
   logic       whack_hit;
   logic       whack_miss;
   logic       timeout_miss;
   logic [3:0] miss_sum;
   logic [2:0] misses_next;
   logic       game_end;
   logic       arm_req;

   tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (state == ST_PLAY),
      .i_clr  (state == ST_ARM),
      .o_tick (tick)
   );

   // A position change releases the hit lock in the same cycle, so a coincident whack is judged fresh.
   always_comb begin
      hit_live     = hit_flag && !i_position_changed;
      whack_seen   = (i_whack != '0) && (i_mole_position < NO_MOLE) && !hit_live;
      whack_hit    = whack_seen && (i_whack == hole_mask(i_mole_position));
      whack_miss   = whack_seen && !whack_hit;
      timeout_miss = i_position_changed && !pending && !hit_flag && (prev_pos < NO_MOLE);
      miss_sum     = {1'b0, o_misses} + 4'(whack_miss) + 4'(timeout_miss);
      misses_next  = (miss_sum >= {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[2:0];
      game_end     = (o_misses >= MISS_MAX) || (o_time_left == '0);
      arm_req      = i_start && (state != ST_ARM);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state             <= ST_IDLE;
         o_restart_game    <= 1'b1;
         o_change_position <= 1'b0;
         o_game_over       <= 1'b0;
         o_score           <= '0;
         o_misses          <= '0;
         o_time_left       <= TIME_INIT;
         hit_flag          <= 1'b0;
         pending           <= 1'b0;
         prev_pos          <= NO_MOLE;
      end else begin
         prev_pos          <= i_mole_position;
         o_change_position <= 1'b0;

         case (state)
            ST_IDLE: begin
               o_restart_game <= 1'b1;
               o_game_over    <= 1'b0;
            end
            ST_ARM: begin
               state          <= ST_PLAY;
               o_restart_game <= 1'b0;
               o_game_over    <= 1'b0;
            end
            ST_PLAY: begin
               if (game_end) begin
                  state       <= ST_OVER;
                  o_game_over <= 1'b1;
               end
               if (whack_hit) begin
                  if (o_score != SCORE_MAX) o_score <= o_score + 1'b1;
                  hit_flag          <= 1'b1;
                  pending           <= 1'b1;
                  o_change_position <= 1'b1;
               end else if (i_position_changed) begin
                  hit_flag <= 1'b0;
                  pending  <= 1'b0;
               end
               o_misses <= misses_next;
               if (tick && (o_time_left != '0)) o_time_left <= o_time_left - 7'd1;
            end
            default: begin
               o_restart_game <= 1'b0;
               o_game_over    <= 1'b1;
            end
         endcase

         // Entering ARM clears the game so the ARM cycle already shows a fresh round.
         if (arm_req) begin
            state             <= ST_ARM;
            o_restart_game    <= 1'b1;
            o_game_over       <= 1'b0;
            o_change_position <= 1'b0;
            o_score           <= '0;
            o_misses          <= '0;
            o_time_left       <= TIME_INIT;
            hit_flag          <= 1'b0;
            pending           <= 1'b0;
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_whack_game_controller.sv
// Scoreboard bench for whack_game_controller with CLK_DIV=10, GAME_SECONDS=5, MAX_MISSES=3.
module tb_whack_game_controller;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic [4:0] i_whack = '0;
   logic [2:0] i_mole_position = 3'd5;
   logic       i_position_changed = 1'b0;
   logic       o_restart_game;
   logic       o_change_position;
   logic       o_game_over;
   logic [7:0] o_score;
   logic [2:0] o_misses;
   logic [6:0] o_time_left;
   logic [1:0] o_state;

   whack_game_controller #(
      .CLK_DIV(10), .GAME_SECONDS(5), .MAX_MISSES(3), .SCORE_W(8)
   ) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_start            (i_start),
      .i_whack            (i_whack),
      .i_mole_position    (i_mole_position),
      .i_position_changed (i_position_changed),
      .o_restart_game     (o_restart_game),
      .o_change_position  (o_change_position),
      .o_game_over        (o_game_over),
      .o_score            (o_score),
      .o_misses           (o_misses),
      .o_time_left        (o_time_left),
      .o_state            (o_state)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string      tag;
      logic [1:0] state;
      int         score;
      int         misses;
      int         time_left;
      logic       chg;
      logic       restart;
      logic       go;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         failures = 0;
   int         play_edges = 0;
   logic [1:0] model_state = 2'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " state"},   32'(o_state), 32'd0);
      check({tag, " restart"}, 32'(o_restart_game), 32'd1);
      check({tag, " chg"},     32'(o_change_position), 32'd0);
      check({tag, " over"},    32'(o_game_over), 32'd0);
      check({tag, " score"},   32'(o_score), 32'd0);
      check({tag, " misses"},  32'(o_misses), 32'd0);
      check({tag, " time"},    32'(o_time_left), 32'd5);
   endtask

   // Drive one cycle of stimulus, queue what the outputs must show after the edge, then compare.
   task automatic step(input string tag, input logic st, input logic [4:0] wh, input logic [2:0] pos,
                       input logic pc, input logic [1:0] e_state, input int e_score, input int e_miss,
                       input logic e_chg);
      exp_t e;
      exp_t g;
      i_start = st;
      i_whack = wh;
      i_mole_position = pos;
      i_position_changed = pc;
      if (model_state == 2'd2) play_edges++;
      if (e_state == 2'd1) play_edges = 0;
      e.tag       = tag;
      e.state     = e_state;
      e.score     = e_score;
      e.misses    = e_miss;
      e.time_left = (play_edges / 10 >= 5) ? 0 : 5 - play_edges / 10;
      e.chg       = e_chg;
      e.restart   = (e_state <= 2'd1);
      e.go        = (e_state == 2'd3);
      model_state = e_state;
      sb_q.push_back(e);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_whack = '0;
      i_position_changed = 1'b0;
      check({tag, " sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
         g = sb_q.pop_front();
         check({g.tag, " state"},   32'(o_state), 32'(g.state));
         check({g.tag, " score"},   32'(o_score), 32'(g.score));
         check({g.tag, " misses"},  32'(o_misses), 32'(g.misses));
         check({g.tag, " time"},    32'(o_time_left), 32'(g.time_left));
         check({g.tag, " chg"},     32'(o_change_position), 32'(g.chg));
         check({g.tag, " restart"}, 32'(o_restart_game), 32'(g.restart));
         check({g.tag, " over"},    32'(o_game_over), 32'(g.go));
      end
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      check_reset("por");
      i_rst = 1'b0;

      // Start: ARM for one cycle with restart held, then PLAY.
      step("t1_arm",   1, 5'b00000, 3'd5, 0, 2'd1, 0, 0, 0);
      step("t1_play",  0, 5'b00000, 3'd2, 0, 2'd2, 0, 0, 0);

      // Hit, one-cycle change request, locked second whack, pending change is not a miss.
      step("t2_hit",   0, 5'b00100, 3'd2, 0, 2'd2, 1, 0, 1);
      step("t2_idle",  0, 5'b00000, 3'd2, 0, 2'd2, 1, 0, 0);
      step("t2_lock",  0, 5'b00100, 3'd2, 0, 2'd2, 1, 0, 0);
      step("t2_chg",   0, 5'b00000, 3'd2, 1, 2'd2, 1, 0, 0);

      // Wrong hole and multi-button misses; whacks with no mole are ignored.
      step("t3_wrong", 0, 5'b01000, 3'd2, 0, 2'd2, 1, 1, 0);
      step("t3_multi", 0, 5'b00110, 3'd2, 0, 2'd2, 1, 2, 0);
      step("t3_nomol", 0, 5'b00001, 3'd5, 0, 2'd2, 1, 2, 0);
      step("t3_from5", 0, 5'b00000, 3'd3, 1, 2'd2, 1, 2, 0);
      // Timeout miss plus a hit on the new position in the same cycle.
      step("t3_simul", 0, 5'b00010, 3'd1, 1, 2'd2, 2, 3, 1);
      step("t3_over",  0, 5'b00000, 3'd1, 0, 2'd3, 2, 3, 0);
      step("t3_frz",   0, 5'b00010, 3'd1, 0, 2'd3, 2, 3, 0);

      // Timeout and whack miss together count two; misses saturate at the limit.
      step("s_arm",    1, 5'b00000, 3'd1, 0, 2'd1, 0, 0, 0);
      step("s_play",   0, 5'b00000, 3'd1, 0, 2'd2, 0, 0, 0);
      step("s_dbl",    0, 5'b01000, 3'd2, 1, 2'd2, 0, 2, 0);
      step("s_sat",    0, 5'b00001, 3'd4, 1, 2'd2, 0, 3, 0);
      step("s_over",   0, 5'b00000, 3'd4, 0, 2'd3, 0, 3, 0);

      // Three unanswered position changes end the game; later whacks are frozen out.
      step("t4_arm",   1, 5'b00000, 3'd4, 0, 2'd1, 0, 0, 0);
      step("t4_play",  0, 5'b00000, 3'd4, 0, 2'd2, 0, 0, 0);
      step("t4_to1",   0, 5'b00000, 3'd1, 1, 2'd2, 0, 1, 0);
      step("t4_to2",   0, 5'b00000, 3'd3, 1, 2'd2, 0, 2, 0);
      step("t4_to3",   0, 5'b00000, 3'd4, 1, 2'd2, 0, 3, 0);
      step("t4_over",  0, 5'b00000, 3'd4, 0, 2'd3, 0, 3, 0);
      step("t4_fhit",  0, 5'b10000, 3'd4, 0, 2'd3, 0, 3, 0);
      step("t4_fmis",  0, 5'b00001, 3'd4, 0, 2'd3, 0, 3, 0);

      // Round timer runs out after 50 PLAY cycles, then a restart brings a fresh round.
      step("t5_arm",   1, 5'b00000, 3'd5, 0, 2'd1, 0, 0, 0);
      step("t5_play",  0, 5'b00000, 3'd5, 0, 2'd2, 0, 0, 0);
      for (int i = 1; i <= 51; i++) begin
         step($sformatf("t5_run%0d", i), 0, 5'b00000, 3'd5, 0, (i <= 50) ? 2'd2 : 2'd3, 0, 0, 0);
      end
      step("t5_rearm", 1, 5'b00000, 3'd5, 0, 2'd1, 0, 0, 0);
      step("t5_replay",0, 5'b00000, 3'd2, 0, 2'd2, 0, 0, 0);

      // Asynchronous reset between edges mid-game.
      step("t6_hit",   0, 5'b00100, 3'd2, 0, 2'd2, 1, 0, 1);
      #3;
      i_rst = 1'b1;
      #1;
      check_reset("t6_arst");
      #2;
      i_rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
